serial_tx: RTL

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx.sv | 123 ++++++++++++
 1 files changed

// File: rtl/serial_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_tx : 8N1 serial transmitter, registered idle-high line, LSB first   |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module serial_tx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       load,
  output logic       ready,
  output logic       busy,
  output logic       Q,
  output logic       done
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             q_reg, q_nxt;
  logic             cnt_end;

  assign cnt_end = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= 8'h00;
      q_reg   <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
      q_reg   <= q_nxt;
    end
  end

  // The line value is computed for the state being entered, so Q lines up
  // with the state register and the start bit appears the cycle after load.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    q_nxt       = q_reg;
    case (state)
      IDLE: begin
        cnt_nxt     = '0;
        bit_idx_nxt = '0;
        q_nxt       = 1'b1;
        if (load) begin
          state_nxt = START;
          shreg_nxt = data_in;
          q_nxt     = 1'b0;
        end
      end
      START: begin
        q_nxt = 1'b0;
        if (cnt_end) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
          q_nxt     = shreg[0];
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        q_nxt = shreg[0];
        if (cnt_end) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt   = STOP;
            bit_idx_nxt = '0;
            q_nxt       = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            shreg_nxt   = {1'b0, shreg[7:1]};
            q_nxt       = shreg[1];
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        q_nxt = 1'b1;
        if (cnt_end) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        q_nxt     = 1'b1;
      end
    endcase
  end

  assign ready = (state == IDLE);
  assign busy  = ~ready;
  assign Q     = q_reg;
  assign done  = (state == STOP) && cnt_end;

endmodule
`default_nettype wire
